// File: rtl/edge_pkg.sv
// Definitions shared by the edge-detection block family: magnitude width,
// default thresholds and the level-count type.
package edge_pkg;

  // Squared-magnitude width for a signed gradient: two squares plus carry.
  function automatic int mag_w(input int grad_w);
    return 2 * grad_w + 1;
  endfunction

  localparam int DEF_GRAD_W = 12;
  localparam int DEF_MAG_W  = 2 * DEF_GRAD_W + 1;

  // Level 0 in the low slice, level 1 above it.
  localparam logic [2*DEF_MAG_W-1:0] THR_INIT_DEFAULT =
    {DEF_MAG_W'(55000), DEF_MAG_W'(9500)};

  typedef logic [2:0] level_cnt_t;

endpackage

// File: rtl/edge_frame_counter.sv
// Per-level edge counter: accumulates hits over a frame and publishes the
// saturated total for one cycle after the frame's last beat.
module edge_frame_counter #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fire_i,
  input  logic             hit_i,
  input  logic             sof_i,
  input  logic             eof_i,
  output logic [CNT_W-1:0] total_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] total_q;
  logic             done_q;

  // A start-of-frame beat discards whatever a frame without eof left behind.
  always_comb begin
    base  = sof_i ? '0 : cnt_q;
    cnt_d = base;
    if (hit_i && (base != '1)) begin
      cnt_d = base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      total_q <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere in clocked logic; the default below is
      // overridden by the later assignment in the same cycle when eof fires.
      done_q <= 1'b0;
      if (fire_i) begin
        if (eof_i) begin
          total_q <= cnt_d;
          done_q  <= 1'b1;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  end

  assign total_o = total_q;
  assign done_o  = done_q;

endmodule

// File: rtl/edge_magnitude_classifier.sv
// Two-stage gradient-magnitude classifier with double-buffered thresholds
// and per-level edge totals per frame.
module edge_magnitude_classifier
  import edge_pkg::*;
#(
  parameter  int GRAD_W     = 12,
  parameter  int NUM_LEVELS = 2,
  parameter  int CNT_W      = 20,
  localparam int MAG_W      = mag_w(GRAD_W),
  parameter  logic [NUM_LEVELS*MAG_W-1:0] THR_INIT = THR_INIT_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_sof,
  input  logic                        in_eof,
  input  logic signed [GRAD_W-1:0]    gx,
  input  logic signed [GRAD_W-1:0]    gy,
  input  logic                        thr_wr_en,
  input  logic [1:0]                  thr_wr_idx,
  input  logic [MAG_W-1:0]            thr_wr_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_LEVELS-1:0]       out_edge,
  output logic [2:0]                  out_level,
  output logic                        out_sof,
  output logic                        out_eof,
  output logic [NUM_LEVELS*CNT_W-1:0] frame_cnt,
  output logic                        cnt_valid
);

  localparam int PROD_W = 2 * GRAD_W;
  typedef logic [MAG_W-1:0] mag_t;

  logic                     s1_valid_q;
  logic signed [PROD_W-1:0] s1_gx2_q, s1_gx2_d;
  logic signed [PROD_W-1:0] s1_gy2_q, s1_gy2_d;
  logic                     s1_sof_q;
  logic                     s1_eof_q;

  logic                     out_valid_q;
  logic [NUM_LEVELS-1:0]    out_edge_q, out_edge_d;
  level_cnt_t               out_level_q, out_level_d;
  logic                     out_sof_q;
  logic                     out_eof_q;

  mag_t                     thr_shadow_q [NUM_LEVELS];
  mag_t                     thr_active_q [NUM_LEVELS];

  mag_t                     mag_sum;
  logic                     s2_adv;
  logic                     in_fire;
  logic                     out_fire;
  logic [NUM_LEVELS-1:0]    frame_done;

  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    // NOTE: every output of this block gets a value before any branch or
    // loop, so no path leaves a variable holding its old value (no latch).
    s1_gx2_d    = gx * gx;
    s1_gy2_d    = gy * gy;
    mag_sum     = {1'b0, s1_gx2_q} + {1'b0, s1_gy2_q};
    out_edge_d  = '0;
    out_level_d = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      out_edge_d[i] = mag_sum > thr_active_q[i];
      out_level_d   = out_level_d + level_cnt_t'(out_edge_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_edge_q  <= '0;
      out_level_q <= '0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_edge_q  <= out_edge_d;
          out_level_q <= out_level_d;
          out_sof_q   <= s1_sof_q;
          out_eof_q   <= s1_eof_q;
        end
      end
    end
  end

  // Stage-1 payload is qualified by s1_valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_gx2_q <= s1_gx2_d;
      s1_gy2_q <= s1_gy2_d;
      s1_sof_q <= in_sof;
      s1_eof_q <= in_eof;
    end
  end

  // Copy-on-sof reads the register value, i.e. the shadow before any
  // write landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this small array is reset on purpose: the thresholds are
      // configuration that must be valid from the first beat; a pure data
      // memory would normally be left unreset.
      for (int i = 0; i < NUM_LEVELS; i++) begin
        thr_shadow_q[i] <= THR_INIT[i*MAG_W +: MAG_W];
        thr_active_q[i] <= THR_INIT[i*MAG_W +: MAG_W];
      end
    end else begin
      if (in_fire && in_sof) begin
        thr_active_q <= thr_shadow_q;
      end
      for (int i = 0; i < NUM_LEVELS; i++) begin
        if (thr_wr_en && (thr_wr_idx == 2'(i))) begin
          thr_shadow_q[i] <= thr_wr_data;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_level
    edge_frame_counter #(
      .CNT_W (CNT_W)
    ) u_frame_counter (
      .clk     (clk),
      .rst     (rst),
      .fire_i  (out_fire),
      .hit_i   (out_edge_q[i]),
      .sof_i   (out_sof_q),
      .eof_i   (out_eof_q),
      .total_o (frame_cnt[i*CNT_W +: CNT_W]),
      .done_o  (frame_done[i])
    );
  end

  assign out_valid = out_valid_q;
  assign out_edge  = out_edge_q;
  assign out_level = out_level_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign cnt_valid = |frame_done;

endmodule
